huffman_decoder: RTL
====================

Name: huffman_decoder

Overview:
Streaming Huffman decoder, the receive-side counterpart of the `huffman` encoder block. Software or a loader FSM writes a code table (symbol, code length, code) into the block. The block then consumes a serial MSB-first bitstream of known total length, one bit per cycle. It emits each decoded symbol on a valid/ready output, and reports completion, symbol count, or a decode error.

Parameters:
- BIT_WIDTH, 8 — symbol width in bits.
- MAX_LEN, 16 — maximum code length in bits.
- NUM_CODES, 16 — number of code-table entries.
- CNT_W, 11 — width of the stream bit-count and symbol-count fields. Matches the encoder `total_bit` width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- tbl_we_i  in  1  table write strobe.
- tbl_addr_i  in  $clog2(NUM_CODES)  table entry index.
- tbl_sym_i  in  BIT_WIDTH  symbol for the entry.
- tbl_len_i  in  $clog2(MAX_LEN+1)  code length; 0 marks the entry invalid.
- tbl_code_i  in  MAX_LEN  code, right-aligned; bits above tbl_len_i are ignored.
- total_bit_i  in  CNT_W  stream length in bits; sampled on start_i.
- start_i  in  1  begin decoding.
- bit_valid_i  in  1  input bit valid.
- bit_i  in  1  input bit, MSB of each code first.
- bit_ready_o  out  1  decoder accepts a bit this cycle.
- sym_valid_o  out  1  decoded symbol valid.
- sym_o  out  BIT_WIDTH  decoded symbol.
- sym_ready_i  in  1  downstream accepts the symbol.
- done_o  out  1  stream fully decoded.
- err_o  out  1  decode error (sticky).
- sym_count_o  out  CNT_W  symbols emitted in the current stream.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - State returns to IDLE.
  - All outputs go to 0: bit_ready_o, sym_valid_o, sym_o, done_o, err_o, sym_count_o.
  - Every table entry length clears to 0.
  - This applies at any point, including mid-stream; no partial symbol survives.
- Table storage: flops.
  - A write takes effect on the clock edge where tbl_we_i=1.
  - Writes are accepted only in IDLE, DONE or ERR; they are ignored in RUN and EMIT.
- State machine: IDLE, RUN, EMIT, DONE, ERR.
- IDLE, DONE, ERR — start_i handling:
  - start_i clears the shift accumulator, current length, bits-consumed counter, sym_count_o, done_o and err_o, and latches total_bit_i.
  - Next state is RUN, or DONE if total_bit_i==0.
  - start_i is ignored in RUN and EMIT.
- RUN:
  - bit_ready_o=1.
  - A bit is accepted when bit_valid_i && bit_ready_o. On acceptance:
    - acc_next = {acc[MAX_LEN-2:0], bit_i}
    - len_next = len+1
    - consumed+1
  - Match check is combinational on acc_next/len_next. An entry matches when its len == len_next and its low len bits equal acc_next[len-1:0].
  - If several entries match, the lowest index wins.
  - On a match: latch the entry symbol into sym_o and go to EMIT.
  - No match with len_next==MAX_LEN: go to ERR.
  - No match with the consumed count reaching total_bit: go to ERR (truncated code).
  - Otherwise stay in RUN.
- EMIT:
  - sym_valid_o=1, bit_ready_o=0.
  - sym_o holds stable until sym_ready_i=1.
  - On the handshake: sym_count_o+1, accumulator and length clear.
  - Then go to DONE if consumed==total_bit, else back to RUN.
- DONE: done_o=1; held until the next start_i.
- ERR: err_o=1; sym_valid_o=0; held until start_i or reset.
- Latency and throughput:
  - Last bit of a code accepted in cycle N → sym_valid_o=1 in cycle N+1.
  - Sustained rate is at most one bit per cycle, plus at least one EMIT cycle per symbol.
- Widths: consumed and sym_count counters are CNT_W bits and do not wrap, since total_bit_i is bounded by CNT_W.
- bit_i is ignored whenever bit_ready_o=0.

Optional Feature:
- Macro: HUFF_DEC_LAST_EN.
- Defined: adds output port sym_last_o (1 bit). It is 1 together with sym_valid_o when the emitted symbol consumed the final stream bit (consumed==total_bit), and 0 otherwise. Reset value 0.
- Undefined: the port does not exist and no extra logic is built.

Test Plan:
- Basic decode:
  - Table: entry0 = 0x41, len 1, code 0; entry1 = 0x42, len 2, code 10; entry2 = 0x43, len 2, code 11.
  - Stream: total_bit_i=6, bits 0,1,0,1,1,0.
  - Required: symbols 0x41, 0x42, 0x43, 0x41 in order; sym_count_o=4; done_o=1; err_o=0.
- Backpressure:
  - Same table and stream, with sym_ready_i held 0 for 3 cycles on each symbol.
  - Required: sym_o stable and bit_ready_o=0 while stalled; output identical to the basic case.
- Invalid code:
  - Table with only entries 0 and 1 of the basic table; stream total_bit_i=2, bits 1,1.
  - Required: err_o=1 one cycle after the second bit; no sym_valid_o; done_o=0.
- Overlength code:
  - Table with only entry0; stream total_bit_i=20, all bits 1.
  - Required: err_o=1 after the 16th bit; the 17th bit is not accepted (bit_ready_o=0).
- Reset and restart:
  - Assert rst_i while in EMIT.
  - Required: all outputs 0 immediately; table cleared.
  - Then start_i with total_bit_i=0 → done_o=1 next cycle, sym_count_o=0.
- Table-write lockout:
  - Issue tbl_we_i during RUN to overwrite entry0 with 0x5A.
  - Required: entry0 still decodes as 0x41.

Source files
------------

// File: rtl/huffman_decoder_if.sv
// Bus bundle for huffman_decoder: table-write port, stream control,
// bit input handshake, symbol output handshake and status.
// Optional HUFF_DEC_LAST_EN adds sym_last_o.
interface huffman_decoder_if #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned NUM_CODES = 16,
  parameter int unsigned CNT_W     = 11
);
  localparam int unsigned AddrW = $clog2(NUM_CODES);
  localparam int unsigned LenW  = $clog2(MAX_LEN + 1);

  logic                 tbl_we_i;
  logic [AddrW-1:0]     tbl_addr_i;
  logic [BIT_WIDTH-1:0] tbl_sym_i;
  logic [LenW-1:0]      tbl_len_i;
  logic [MAX_LEN-1:0]   tbl_code_i;
  logic [CNT_W-1:0]     total_bit_i;
  logic                 start_i;
  logic                 bit_valid_i;
  logic                 bit_i;
  logic                 bit_ready_o;
  logic                 sym_valid_o;
  logic [BIT_WIDTH-1:0] sym_o;
  logic                 sym_ready_i;
  logic                 done_o;
  logic                 err_o;
  logic [CNT_W-1:0]     sym_count_o;
`ifdef HUFF_DEC_LAST_EN
  logic                 sym_last_o;
`endif

  modport master (
    output tbl_we_i, tbl_addr_i, tbl_sym_i, tbl_len_i, tbl_code_i,
    output total_bit_i, start_i, bit_valid_i, bit_i, sym_ready_i,
    input  bit_ready_o, sym_valid_o, sym_o, done_o, err_o, sym_count_o
`ifdef HUFF_DEC_LAST_EN
    , input sym_last_o
`endif
  );

  modport slave (
    input  tbl_we_i, tbl_addr_i, tbl_sym_i, tbl_len_i, tbl_code_i,
    input  total_bit_i, start_i, bit_valid_i, bit_i, sym_ready_i,
    output bit_ready_o, sym_valid_o, sym_o, done_o, err_o, sym_count_o
`ifdef HUFF_DEC_LAST_EN
    , output sym_last_o
`endif
  );
endinterface

// File: rtl/huffman_decoder.sv
// Streaming Huffman decoder. Consumes an MSB-first bitstream one bit per cycle,
// matches the growing code against a flop-based code table and emits each
// decoded symbol on a valid/ready output.
// Optional feature macro HUFF_DEC_LAST_EN: adds sym_last_o on the bus.
module huffman_decoder #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned NUM_CODES = 16,
  parameter int unsigned CNT_W     = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  huffman_decoder_if.slave  bus
);
  localparam int unsigned LenW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {StIdle, StRun, StEmit, StDone, StErr} state_e;

  state_e               state_q, state_d;
  logic [MAX_LEN-1:0]   acc_q, acc_d;
  logic [LenW-1:0]      len_q, len_d;
  logic [CNT_W-1:0]     consumed_q, consumed_d;
  logic [CNT_W-1:0]     total_q, total_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [BIT_WIDTH-1:0] sym_q, sym_d;

  logic [BIT_WIDTH-1:0] tbl_sym_q  [NUM_CODES];
  logic [LenW-1:0]      tbl_len_q  [NUM_CODES];
  logic [MAX_LEN-1:0]   tbl_code_q [NUM_CODES];

  logic                 tbl_wr_en;
  logic [MAX_LEN-1:0]   acc_shift;
  logic [LenW-1:0]      len_inc;
  logic                 hit;
  logic [BIT_WIDTH-1:0] hit_sym;
  logic [MAX_LEN-1:0]   mask;

  // Table may only change while no stream is being decoded.
  assign tbl_wr_en = bus.tbl_we_i &&
                     (state_q == StIdle || state_q == StDone || state_q == StErr);

  assign acc_shift = {acc_q[MAX_LEN-2:0], bus.bit_i};
  assign len_inc   = len_q + 1'b1;

  // Code table storage; reset invalidates every entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CODES; i++) begin
        tbl_sym_q[i]  <= '0;
        tbl_len_q[i]  <= '0;
        tbl_code_q[i] <= '0;
      end
    end else if (tbl_wr_en) begin
      tbl_sym_q[bus.tbl_addr_i]  <= bus.tbl_sym_i;
      tbl_len_q[bus.tbl_addr_i]  <= bus.tbl_len_i;
      tbl_code_q[bus.tbl_addr_i] <= bus.tbl_code_i;
    end
  end

  // Match the shifted accumulator against all entries; scanning downward
  // lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_sym = '0;
    mask    = '0;
    for (int i = NUM_CODES - 1; i >= 0; i--) begin
      mask = ~({MAX_LEN{1'b1}} << tbl_len_q[i]);
      if (tbl_len_q[i] == len_inc && ((acc_shift ^ tbl_code_q[i]) & mask) == '0) begin
        hit     = 1'b1;
        hit_sym = tbl_sym_q[i];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      len_q      <= '0;
      consumed_q <= '0;
      total_q    <= '0;
      count_q    <= '0;
      sym_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      len_q      <= len_d;
      consumed_q <= consumed_d;
      total_q    <= total_d;
      count_q    <= count_d;
      sym_q      <= sym_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    len_d      = len_q;
    consumed_d = consumed_q;
    total_d    = total_q;
    count_d    = count_q;
    sym_d      = sym_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (bus.start_i) begin
          acc_d      = '0;
          len_d      = '0;
          consumed_d = '0;
          count_d    = '0;
          total_d    = bus.total_bit_i;
          state_d    = (bus.total_bit_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (bus.bit_valid_i) begin
          acc_d      = acc_shift;
          len_d      = len_inc;
          consumed_d = consumed_q + 1'b1;
          if (hit) begin
            sym_d   = hit_sym;
            state_d = StEmit;
          end else if (len_inc == LenW'(MAX_LEN) || consumed_d == total_q) begin
            // Overlong or truncated code.
            state_d = StErr;
          end
        end
      end
      StEmit: begin
        if (bus.sym_ready_i) begin
          count_d = count_q + 1'b1;
          acc_d   = '0;
          len_d   = '0;
          state_d = (consumed_q == total_q) ? StDone : StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decode straight from state so reset clears them at once.
  assign bus.bit_ready_o = (state_q == StRun);
  assign bus.sym_valid_o = (state_q == StEmit);
  assign bus.done_o      = (state_q == StDone);
  assign bus.err_o       = (state_q == StErr);
  assign bus.sym_o       = sym_q;
  assign bus.sym_count_o = count_q;
`ifdef HUFF_DEC_LAST_EN
  assign bus.sym_last_o  = (state_q == StEmit) && (consumed_q == total_q);
`endif

endmodule
